freq_meter_ctrl: RTL and testbench

Measurement sequencer and auto-ranging controller for the frequency meter. It times the measurement gate and counts edges from the prescaler output. Between gates it selects the prescaler ratio through `modecontrol` (0 = divide-by-2, 1 = divide-by-10). It then publishes the scaled input frequency as one result per gate.

---
 rtl/freq_meter_ctrl.sv | 154 +++++++++++++++
 tb/tb_freq_meter_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter_ctrl.sv
// Frequency-meter sequencer: times the gate, counts synchronized prescaler edges,
// auto-ranges the prescaler between gates and publishes one scaled result per gate.
module freq_meter_ctrl #(
  parameter int GATE_CYCLES   = 1000000,
  parameter int SETTLE_CYCLES = 16,
  parameter int COUNT_W       = 16,
  parameter int HIGH_TH       = 60000,
  parameter int LOW_TH        = 5000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               auto_en,
  input  logic               manual_mode,
  input  logic               sig_in,
  output logic               modecontrol,
  output logic               gate,
  output logic               busy,
  output logic [COUNT_W+3:0] result,
  output logic               result_valid,
  output logic               overrange,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_GATE   = 2'd2,
    S_EVAL   = 2'd3
  } state_t;

  localparam int RW = COUNT_W + 4;
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [GW-1:0]      GATE_LAST   = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0]      SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX     = '1;
  // Thresholds carry one extra bit so a threshold at or above full scale never aliases.
  localparam logic [COUNT_W:0]   HIGH_V      = (COUNT_W + 1)'(HIGH_TH);
  localparam logic [COUNT_W:0]   LOW_V       = (COUNT_W + 1)'(LOW_TH);

  state_t              state;
  logic                sync1, sync2, hist;
  logic                edge_pulse;
  logic [SW-1:0]       settle_cnt;
  logic [GW-1:0]       gate_cnt;
  logic [COUNT_W-1:0]  cnt;
  logic                sat;
  logic                want_switch;
  logic [RW-1:0]       cnt_ext;
  logic [RW-1:0]       scaled;

  assign edge_pulse = sync2 & ~hist;
  assign gate       = (state == S_GATE);
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;
  assign cnt_ext    = {4'b0000, cnt};

  // Range decision uses the range that was active for the gate just finished.
  always_comb begin
    want_switch = 1'b0;
    if (auto_en) begin
      if (!modecontrol)
        want_switch = sat || ({1'b0, cnt} > HIGH_V);
      else
        want_switch = !sat && ({1'b0, cnt} < LOW_V);
    end else begin
      want_switch = (manual_mode != modecontrol);
    end
  end

  always_comb begin
    scaled = cnt_ext << 1;
    if (modecontrol)
      scaled = (cnt_ext << 3) + (cnt_ext << 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      hist         <= 1'b0;
      settle_cnt   <= '0;
      gate_cnt     <= '0;
      cnt          <= '0;
      sat          <= 1'b0;
      modecontrol  <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overrange    <= 1'b0;
    end else begin
      sync1        <= sig_in;
      sync2        <= sync1;
      hist         <= sync2;
      result_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (run) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
            cnt        <= '0;
            sat        <= 1'b0;
          end
        end

        S_SETTLE: begin
          cnt <= '0;
          sat <= 1'b0;
          if (settle_cnt == SETTLE_LAST) begin
            state    <= S_GATE;
            gate_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        S_GATE: begin
          if (edge_pulse) begin
            if (cnt == CNT_MAX)
              sat <= 1'b1;
            else
              cnt <= cnt + COUNT_W'(1);
          end
          if (gate_cnt == GATE_LAST)
            state <= S_EVAL;
          else
            gate_cnt <= gate_cnt + GW'(1);
        end

        S_EVAL: begin
          // Edges arriving here are deliberately dropped.
          if (want_switch) begin
            modecontrol <= ~modecontrol;
            settle_cnt  <= '0;
            state       <= run ? S_SETTLE : S_IDLE;
          end else begin
            result       <= scaled;
            overrange    <= sat & modecontrol;
            result_valid <= 1'b1;
            cnt          <= '0;
            sat          <= 1'b0;
            gate_cnt     <= '0;
            state        <= run ? S_GATE : S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Bench for freq_meter_ctrl: directed table, hand-written range/stop/reset sequences,
// and randomized segments scored against an arithmetic model of the measurement.
module tb_freq_meter_ctrl;

  localparam int G  = 1000;
  localparam int S  = 4;
  localparam int W  = 8;
  localparam int HI = 200;
  localparam int LO = 15;
  localparam int RW = W + 4;
  localparam int FIRST_LAT = S + G + 1;
  localparam int SW_LAT    = S + G + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          auto_en;
  logic          manual_mode;
  logic          sig_in;
  logic          modecontrol;
  logic          gate;
  logic          busy;
  logic [RW-1:0] result;
  logic          result_valid;
  logic          overrange;
  logic [1:0]    state_dbg;

  freq_meter_ctrl #(
    .GATE_CYCLES(G), .SETTLE_CYCLES(S), .COUNT_W(W), .HIGH_TH(HI), .LOW_TH(LO)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .auto_en(auto_en), .manual_mode(manual_mode),
    .sig_in(sig_in), .modecontrol(modecontrol), .gate(gate), .busy(busy),
    .result(result), .result_valid(result_valid), .overrange(overrange),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rv_count = 0;
  always @(negedge clk) if (result_valid === 1'b1) rv_count = rv_count + 1;

  int n_checks = 0;
  int n_err    = 0;

  // Prescaler model: period per0 in range 0, per1 in range 1.
  int per0 = 10;
  int per1 = 50;
  int ph   = 0;
  initial begin
    int cur;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      cur = (modecontrol === 1'b1) ? per1 : per0;
      if (ph + 1 >= cur) ph = 0;
      else ph = ph + 1;
      sig_in = (ph < cur / 2);
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_true(input string name, input bit ok, input logic [31:0] act);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, outside allowed set", name, act);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Raises run; n is the cycle number of the edge that samples it.
  task automatic start_run(output int n);
    @(negedge clk);
    run = 1'b1;
    n = cyc + 1;
  endtask

  task automatic wait_result(input int budget, output bit got, output logic [RW-1:0] r,
                             output bit ov, output bit mc, output int at);
    got = 0; r = '0; ov = 0; mc = 0; at = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        got = 1; r = result; ov = overrange; mc = modecontrol; at = cyc;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge clk);
      if (busy === 1'b0) idle = 1;
    end
    chk({name, "_idle"}, {31'd0, idle}, 32'd1);
  endtask

  // ---------------- reference model ----------------
  function automatic void predict(input int p, input bit au, input bit man, input bit r_in,
                                  output bit r_out, output int nsw, output int res,
                                  output bit ov);
    int edges, c;
    bit sat, sw, r, done;
    r = r_in; nsw = 0; res = 0; ov = 0; done = 0;
    for (int k = 0; k < 3 && !done; k++) begin
      edges = G / (r ? 5 * p : p);
      sat   = edges > (2 ** W - 1);
      c     = sat ? (2 ** W - 1) : edges;
      if (au) sw = r ? (c < LO && !sat) : (sat || c > HI);
      else    sw = (man != r);
      if (sw) begin
        r = !r; nsw++;
      end else begin
        res = r ? c * 10 : c * 2;
        ov  = sat && r;
        done = 1;
      end
    end
    r_out = r;
  endfunction

  logic [RW+1:0] exp_q[$];

  typedef struct {
    int p0; int p1; bit au; bit man; int nsw; int res; bit ov; bit mc;
  } vec_t;

  vec_t vt[5];

  initial begin
    bit            got, ov, mc, r_mod, r_next;
    logic [RW-1:0] r;
    logic [RW+1:0] e;
    int            n, at, at2, base, nsw, res, p;
    bit            au, man, ovm, seen;
    int            plist[10];

    reset = 1'b1; run = 1'b0; auto_en = 1'b1; manual_mode = 1'b0;
    apply_reset();
    chk("rst_modecontrol", {31'd0, modecontrol}, 32'd0);
    chk("rst_gate", {31'd0, gate}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_overrange", {31'd0, overrange}, 32'd0);

    vt[0] = '{p0: 10, p1: 50, au: 1, man: 0, nsw: 0, res: 200,  ov: 0, mc: 0};
    vt[1] = '{p0: 4,  p1: 20, au: 1, man: 0, nsw: 1, res: 500,  ov: 0, mc: 1};
    vt[2] = '{p0: 2,  p1: 2,  au: 0, man: 1, nsw: 1, res: 2550, ov: 1, mc: 1};
    vt[3] = '{p0: 2,  p1: 10, au: 0, man: 0, nsw: 0, res: 510,  ov: 0, mc: 0};
    vt[4] = '{p0: 2,  p1: 10, au: 1, man: 0, nsw: 1, res: 1000, ov: 0, mc: 1};

    // Each vector: first result with latency, second one G+1 later, then run drop.
    for (int i = 0; i < 5; i++) begin
      apply_reset();
      per0 = vt[i].p0; per1 = vt[i].p1;
      auto_en = vt[i].au; manual_mode = vt[i].man;
      repeat (10) @(negedge clk);
      start_run(n);
      wait_result(FIRST_LAT + 2 * SW_LAT + 50, got, r, ov, mc, at);
      chk($sformatf("v%0d_got1", i), {31'd0, got}, 32'd1);
      chk($sformatf("v%0d_result1", i), 32'(r), 32'(vt[i].res));
      chk($sformatf("v%0d_overrange1", i), {31'd0, ov}, {31'd0, vt[i].ov});
      chk($sformatf("v%0d_mode1", i), {31'd0, mc}, {31'd0, vt[i].mc});
      chk($sformatf("v%0d_latency", i), 32'(at - n), 32'(FIRST_LAT + vt[i].nsw * SW_LAT));
      wait_result(G + 50, got, r, ov, mc, at2);
      chk($sformatf("v%0d_result2", i), 32'(r), 32'(vt[i].res));
      chk($sformatf("v%0d_spacing", i), 32'(at2 - at), 32'(G + 1));
      @(negedge clk);
      run = 1'b0;
      base = rv_count;
      wait_result(G + 50, got, r, ov, mc, at);
      chk($sformatf("v%0d_stop_result", i), 32'(r), 32'(vt[i].res));
      wait_idle($sformatf("v%0d_stop", i));
      repeat (50) @(negedge clk);
      chk($sformatf("v%0d_stop_count", i), 32'(rv_count - base), 32'd1);
    end

    // Down-range: reach range 1 manually, then let auto ranging drop back.
    apply_reset();
    per0 = 80; per1 = 400; auto_en = 1'b0; manual_mode = 1'b1;
    repeat (10) @(negedge clk);
    base = rv_count;
    start_run(n);
    seen = 0; at = 0;
    for (int i = 0; i < FIRST_LAT + 50 && !seen; i++) begin
      @(negedge clk);
      if (modecontrol === 1'b1) begin seen = 1; at = cyc; end
    end
    chk("down_up_seen", {31'd0, seen}, 32'd1);
    chk("down_up_time", 32'(at - n), 32'(FIRST_LAT));
    auto_en = 1'b1;
    wait_result(2 * SW_LAT + 50, got, r, ov, mc, at);
    chk("down_got", {31'd0, got}, 32'd1);
    chk_true("down_result", (r == 24) || (r == 26), 32'(r));
    chk("down_mode", {31'd0, mc}, 32'd0);
    chk("down_overrange", {31'd0, ov}, 32'd0);
    chk("down_latency", 32'(at - n), 32'(FIRST_LAT + 2 * SW_LAT));
    @(negedge clk);
    chk("down_no_early_result", 32'(rv_count - base), 32'd1);
    run = 1'b0;
    wait_result(G + 50, got, r, ov, mc, at);
    wait_idle("down");

    // Reset in the middle of a gate while in range 1 with a result held.
    apply_reset();
    per0 = 4; per1 = 20; auto_en = 1'b1;
    repeat (10) @(negedge clk);
    start_run(n);
    wait_result(FIRST_LAT + SW_LAT + 50, got, r, ov, mc, at);
    chk("rstmid_pre_result", 32'(r), 32'd500);
    repeat (300) @(negedge clk);
    chk("rstmid_in_gate", {31'd0, gate}, 32'd1);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    chk("rstmid_modecontrol", {31'd0, modecontrol}, 32'd0);
    chk("rstmid_gate", {31'd0, gate}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_result", 32'(result), 32'd0);
    chk("rstmid_valid", {31'd0, result_valid}, 32'd0);
    chk("rstmid_overrange", {31'd0, overrange}, 32'd0);
    reset = 1'b0;
    base = rv_count;
    repeat (G + 100) @(negedge clk);
    chk("rstmid_no_result", 32'(rv_count - base), 32'd0);
    chk("rstmid_idle", {31'd0, busy}, 32'd0);

    // Randomized segments; periods chosen so every window holds an exact edge count.
    plist = '{2, 4, 8, 10, 20, 25, 40, 50, 100, 200};
    apply_reset();
    r_mod = 0;
    for (int seg = 0; seg < 8; seg++) begin
      p   = plist[$urandom_range(0, 9)];
      au  = ($urandom_range(0, 3) != 0);
      man = $urandom_range(0, 1);
      predict(p, au, man, r_mod, r_next, nsw, res, ovm);
      r_mod = r_next;
      per0 = p; per1 = 5 * p; auto_en = au; manual_mode = man;
      repeat (10) @(negedge clk);
      for (int k = 0; k < 3; k++) exp_q.push_back({r_next, ovm, RW'(res)});
      start_run(n);
      for (int k = 0; k < 3; k++) begin
        wait_result((k == 0) ? FIRST_LAT + 2 * SW_LAT + 50 : G + 50, got, r, ov, mc, at2);
        e = exp_q.pop_front();
        chk($sformatf("rnd%0d_got%0d", seg, k), {31'd0, got}, 32'd1);
        chk($sformatf("rnd%0d_result%0d", seg, k), 32'(r), 32'(e[RW-1:0]));
        chk($sformatf("rnd%0d_overrange%0d", seg, k), {31'd0, ov}, {31'd0, e[RW]});
        chk($sformatf("rnd%0d_mode%0d", seg, k), {31'd0, mc}, {31'd0, e[RW+1]});
        if (k == 0) chk($sformatf("rnd%0d_latency", seg), 32'(at2 - n), 32'(FIRST_LAT + nsw * SW_LAT));
        else        chk($sformatf("rnd%0d_spacing%0d", seg, k), 32'(at2 - at), 32'(G + 1));
        at = at2;
        if (k == 1) begin
          @(negedge clk);
          run = 1'b0;
        end
      end
      wait_idle($sformatf("rnd%0d", seg));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
